// File: rtl/hsst_frame_pkg.sv
// hsst_frame_pkg: code words, K flags and framer states shared by the TX framer and RX deframer
package hsst_frame_pkg;
  localparam logic [15:0] IDLE_WORD = 16'h50BC;
  localparam logic [15:0] SOF_WORD  = 16'h00FB;
  localparam logic [15:0] EOF_WORD  = 16'h00FD;
  localparam logic [15:0] FILL_WORD = 16'h00F7;
  localparam logic [1:0]  K_CTRL    = 2'b01;
  localparam logic [1:0]  K_DATA    = 2'b00;
  typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_HDR, ST_PAYLOAD, ST_EOF, ST_IFG} state_t;
endpackage

// File: rtl/hsst_tx_framer.sv
// hsst_tx_framer: frames FIFO words into SOF/HDR/PAYLOAD/EOF packets with IFG spacing on an HSST TX lane
module hsst_tx_framer
  import hsst_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 640,
  parameter int IFG_LEN    = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  tx_en,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [1:0]            tx_kchar,
  output logic                  busy,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           fill_cnt
);
  state_t                r_state, w_next;
  logic [15:0]           r_seq, r_word_cnt, r_fill_cnt, r_pkt_cnt;
  logic [3:0]            r_ifg_cnt;
  logic [DATA_WIDTH-1:0] w_data;
  logic [1:0]            w_k;
  logic                  w_start;
  assign w_start  = tx_en && fifo_rd_vld;
  assign pkt_cnt  = r_pkt_cnt;
  assign fill_cnt = r_fill_cnt;
  // state register; reset abandons any packet in flight
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end
  // next state; the last IFG cycle may launch SOF directly so the gap is exactly IFG_LEN words
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = w_start ? ST_SOF : ST_IDLE;
      ST_SOF:     w_next = ST_HDR;
      ST_HDR:     w_next = ST_PAYLOAD;
      ST_PAYLOAD: w_next = (fifo_rd_en && r_word_cnt == 16'(PKT_LEN - 1)) ? ST_EOF : ST_PAYLOAD;
      ST_EOF:     w_next = ST_IFG;
      ST_IFG:     w_next = (r_ifg_cnt == 4'(IFG_LEN - 1)) ? (w_start ? ST_SOF : ST_IDLE) : ST_IFG;
      default:    w_next = ST_IDLE;
    endcase
  end
  // outputs: pop request, busy flag and the word to register for the next cycle
  always_comb begin
    fifo_rd_en = (r_state == ST_PAYLOAD) && fifo_rd_vld && (r_word_cnt < 16'(PKT_LEN));
    busy       = (r_state == ST_SOF) || (r_state == ST_HDR) || (r_state == ST_PAYLOAD) || (r_state == ST_EOF);
    w_data     = IDLE_WORD;
    w_k        = K_CTRL;
    case (r_state)
      ST_SOF:     w_data = SOF_WORD;
      ST_HDR:     begin w_data = r_seq; w_k = K_DATA; end
      ST_PAYLOAD: begin w_data = fifo_rd_en ? fifo_rd_data : FILL_WORD; w_k = fifo_rd_en ? K_DATA : K_CTRL; end
      ST_EOF:     w_data = EOF_WORD;
      default:    w_data = IDLE_WORD;
    endcase
  end
  // datapath: registered TX word, sequence number, pop/IFG counters and statistics
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      tx_data    <= IDLE_WORD;
      tx_kchar   <= K_CTRL;
      r_seq      <= '0;
      r_word_cnt <= '0;
      r_ifg_cnt  <= '0;
      r_pkt_cnt  <= '0;
      r_fill_cnt <= '0;
    end else begin
      tx_data    <= w_data;
      tx_kchar   <= w_k;
      r_seq      <= (r_state == ST_HDR) ? r_seq + 16'd1 : r_seq;
      r_word_cnt <= (r_state == ST_SOF) ? 16'd0 : r_word_cnt + 16'(fifo_rd_en);
      r_ifg_cnt  <= (r_state == ST_IFG) ? r_ifg_cnt + 4'd1 : 4'd0;
      r_pkt_cnt  <= (r_state == ST_EOF) ? r_pkt_cnt + 16'd1 : r_pkt_cnt;
      r_fill_cnt <= (r_state == ST_PAYLOAD && !fifo_rd_en && r_fill_cnt != 16'hFFFF) ? r_fill_cnt + 16'd1 : r_fill_cnt;
    end
  end
endmodule

// File: tb/tb_hsst_tx_framer.sv
// tb_hsst_tx_framer: directed checks of framing, FILL insertion, IFG, tx_en drop, reset and fill saturation
module tb_hsst_tx_framer;
  localparam logic [15:0] IDLE_W = 16'h50BC, SOF_W = 16'h00FB, EOF_W = 16'h00FD, FILL_W = 16'h00F7;
  logic        clk = 1'b0, rst = 1'b1, tx_en = 1'b0;
  logic        fifo_rd_en, fifo_rd_vld, busy;
  logic [15:0] fifo_rd_data, tx_data, pkt_cnt, fill_cnt;
  logic [1:0]  tx_kchar;
  logic [15:0] mem [0:63];
  int          head = 0, tail = 0, pops = 0, p0;
  int          vecs = 0, errs = 0;
  assign fifo_rd_vld  = head < tail;
  assign fifo_rd_data = mem[head[5:0]];
  always #5 clk = ~clk;
  always @(posedge clk) if (fifo_rd_en) begin head <= head + 1; pops <= pops + 1; end
  hsst_tx_framer #(.DATA_WIDTH(16), .PKT_LEN(4), .IFG_LEN(2)) dut (
    .rd_clk(clk), .rd_rst(rst), .tx_en(tx_en), .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data), .tx_data(tx_data), .tx_kchar(tx_kchar), .busy(busy),
    .pkt_cnt(pkt_cnt), .fill_cnt(fill_cnt));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [15:0] w);
    mem[tail[5:0]] = w;
    tail++;
  endtask
  task automatic word(input string tag, input logic [15:0] d, input logic [1:0] k);
    @(negedge clk);
    chk(tag, {14'd0, tx_kchar, tx_data}, {14'd0, k, d});
  endtask
  task automatic wait_sof(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (tx_data == SOF_W) && (tx_kchar == 2'b01);
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset;
    chk("rst_data", {16'd0, tx_data}, {16'd0, IDLE_W});
    chk("rst_k", {30'd0, tx_kchar}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rden", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
    chk("rst_fill", {16'd0, fill_cnt}, 32'd0);
    // basic packet
    for (int i = 1; i <= 4; i++) push(16'(i));
    tx_en = 1'b1;
    wait_sof("t1_sof");
    word("t1_hdr", 16'h0000, 2'b00);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 4; i++) word("t1_pay", 16'(i), 2'b00);
    word("t1_eof", EOF_W, 2'b01);
    chk("t1_pkt", {16'd0, pkt_cnt}, 32'd1);
    word("t1_ifg0", IDLE_W, 2'b01);
    word("t1_ifg1", IDLE_W, 2'b01);
    chk("t1_pops", pops, 32'd4);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    // back-to-back packets with exactly IFG_LEN idles
    tx_en = 1'b0;
    do_reset;
    for (int i = 0; i < 8; i++) push(16'h0011 + 16'(i));
    tx_en = 1'b1;
    wait_sof("t2_sof_a");
    word("t2_hdr_a", 16'h0000, 2'b00);
    for (int i = 0; i < 4; i++) word("t2_pay_a", 16'h0011 + 16'(i), 2'b00);
    word("t2_eof_a", EOF_W, 2'b01);
    word("t2_gap0", IDLE_W, 2'b01);
    word("t2_gap1", IDLE_W, 2'b01);
    word("t2_sof_b", SOF_W, 2'b01);
    word("t2_hdr_b", 16'h0001, 2'b00);
    for (int i = 4; i < 8; i++) word("t2_pay_b", 16'h0011 + 16'(i), 2'b00);
    word("t2_eof_b", EOF_W, 2'b01);
    chk("t2_pkt", {16'd0, pkt_cnt}, 32'd2);
    // FIFO underrun: five FILL words
    do_reset;
    p0 = pops;
    push(16'h0001);
    push(16'h0002);
    wait_sof("t3_sof");
    word("t3_hdr", 16'h0000, 2'b00);
    tx_en = 1'b0;
    word("t3_p1", 16'h0001, 2'b00);
    word("t3_p2", 16'h0002, 2'b00);
    for (int i = 0; i < 5; i++) word("t3_fill", FILL_W, 2'b01);
    push(16'h0003);
    push(16'h0004);
    push(16'h0005);
    word("t3_p3", 16'h0003, 2'b00);
    word("t3_p4", 16'h0004, 2'b00);
    word("t3_eof", EOF_W, 2'b01);
    chk("t3_fillcnt", {16'd0, fill_cnt}, 32'd5);
    chk("t3_pops", pops - p0, 32'd4);
    // tx_en low with data waiting: no new packet
    for (int i = 0; i < 4; i++) word("t3_hold", IDLE_W, 2'b01);
    chk("t3_hold_busy", {31'd0, busy}, 32'd0);
    // tx_en dropped mid-payload
    push(16'h0006);
    push(16'h0007);
    push(16'h0008);
    tx_en = 1'b1;
    wait_sof("t4_sof");
    word("t4_hdr", 16'h0001, 2'b00);
    tx_en = 1'b0;
    for (int i = 5; i <= 8; i++) word("t4_pay", 16'(i), 2'b00);
    word("t4_eof", EOF_W, 2'b01);
    for (int i = 9; i <= 12; i++) push(16'(i));
    for (int i = 0; i < 6; i++) begin
      word("t4_noSOF", IDLE_W, 2'b01);
      chk("t4_busy", {31'd0, busy}, 32'd0);
    end
    chk("t4_pkt", {16'd0, pkt_cnt}, 32'd2);
    // reset mid-payload
    tx_en = 1'b1;
    wait_sof("t5_sof");
    word("t5_hdr", 16'h0002, 2'b00);
    word("t5_p9", 16'h0009, 2'b00);
    rst = 1'b1;
    #1;
    chk("t5_data", {16'd0, tx_data}, {16'd0, IDLE_W});
    chk("t5_k", {30'd0, tx_kchar}, 32'd1);
    chk("t5_rden", {31'd0, fifo_rd_en}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_pkt", {16'd0, pkt_cnt}, 32'd0);
    chk("t5_fill", {16'd0, fill_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(16'h000D);
    wait_sof("t5_sof2");
    word("t5_hdr2", 16'h0000, 2'b00);
    for (int i = 10; i <= 13; i++) word("t5_pay", 16'(i), 2'b00);
    word("t5_eof", EOF_W, 2'b01);
    chk("t5_pkt2", {16'd0, pkt_cnt}, 32'd1);
    // fill_cnt saturation
    tx_en = 1'b0;
    word("t6_idle", IDLE_W, 2'b01);
    word("t6_idle", IDLE_W, 2'b01);
    force dut.r_fill_cnt = 16'hFFFE;
    #1;
    release dut.r_fill_cnt;
    push(16'h0021);
    tx_en = 1'b1;
    wait_sof("t6_sof");
    word("t6_hdr", 16'h0001, 2'b00);
    tx_en = 1'b0;
    word("t6_p", 16'h0021, 2'b00);
    word("t6_fill0", FILL_W, 2'b01);
    chk("t6_fc0", {16'd0, fill_cnt}, 32'h0000FFFF);
    word("t6_fill1", FILL_W, 2'b01);
    word("t6_fill2", FILL_W, 2'b01);
    chk("t6_fc2", {16'd0, fill_cnt}, 32'h0000FFFF);
    push(16'h0022);
    push(16'h0023);
    push(16'h0024);
    for (int i = 2; i <= 4; i++) word("t6_pay", 16'h0020 + 16'(i), 2'b00);
    word("t6_eof", EOF_W, 2'b01);
    chk("t6_fc_end", {16'd0, fill_cnt}, 32'h0000FFFF);
    chk("t6_pkt", {16'd0, pkt_cnt}, 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
